// File: rtl/trap_pkg.sv
// Shared constants and types for the trap/elf frame scheduler:
// colours, coordinate widths, FSM states and the pixel tag carried down the delay line.
package trap_pkg;

    localparam int COLOUR_W         = 3;
    localparam int COORD_W          = 9;
    localparam int SCREEN_W_DEFAULT = 320;
    localparam int SCREEN_H_DEFAULT = 240;

    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [COORD_W-1:0]  coord_t;

    localparam colour_t BLACK  = 3'b000;
    localparam colour_t RED    = 3'b100;
    localparam colour_t YELLOW = 3'b110;
    localparam colour_t WHITE  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One issued coordinate travelling alongside the renderers' pipelines.
    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } pixel_tag_t;

endpackage

// File: rtl/coord_delay_line.sv
// Fixed-depth shift register that keeps each issued coordinate in step with
// the registered colour/hit returns of the layer renderers.
module coord_delay_line
    import trap_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  pixel_tag_t tag_in,
    output pixel_tag_t tag_out
);

    pixel_tag_t stages [DEPTH];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            // NOTE: every stage is cleared, not just the valid bits of the head;
            // a mid-frame reset must never let a stale pixel emerge afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/trap_frame_scheduler.sv
// Raster-scans one frame per accepted frame_tick, realigns renderer returns with
// their coordinates, resolves layer priority and drives registered VGA plot strobes.
module trap_frame_scheduler
    import trap_pkg::*;
#(
    parameter int      SCREEN_W       = SCREEN_W_DEFAULT,
    parameter int      SCREEN_H       = SCREEN_H_DEFAULT,
    parameter int      LAYERS         = 3,
    parameter int      RENDER_LATENCY = 1,
    parameter colour_t BG_COLOUR      = BLACK
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         frame_tick,
    output logic [COORD_W-1:0]           x_cord,
    output logic [COORD_W-1:0]           y_cord,
    input  logic [COLOUR_W*LAYERS-1:0]   layer_colour,
    input  logic [LAYERS-1:0]            layer_hit,
    output logic [COORD_W-1:0]           vga_x,
    output logic [COORD_W-1:0]           vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam coord_t X_LAST = COORD_W'(SCREEN_W - 1);
    localparam coord_t Y_LAST = COORD_W'(SCREEN_H - 1);

    state_t     state;
    pixel_tag_t issued;
    pixel_tag_t aligned;
    colour_t    resolved;
    logic       last_pixel;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            x_cord <= '0;
            y_cord <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state  <= ST_SCAN;
                        x_cord <= '0;
                        y_cord <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (x_cord == X_LAST) begin
                        if (y_cord == Y_LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            x_cord <= '0;
                            y_cord <= y_cord + 1'b1;
                        end
                    end else begin
                        x_cord <= x_cord + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // frame_done marks the cycle of the final plot; leave right after it.
                    if (frame_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign issued = '{valid: (state == ST_SCAN), x: x_cord, y: y_cord};

    coord_delay_line #(
        .DEPTH (RENDER_LATENCY)
    ) u_delay (
        .clock   (clock),
        .resetn  (resetn),
        .tag_in  (issued),
        .tag_out (aligned)
    );

    // NOTE: the default assignment before the loop keeps this purely combinational;
    // without it an all-miss pixel would infer a latch on resolved.
    always_comb begin
        resolved = BG_COLOUR;
        for (int i = 0; i < LAYERS; i++) begin
            if (layer_hit[i]) begin
                resolved = layer_colour[COLOUR_W*i +: COLOUR_W];
            end
        end
    end

    assign last_pixel = aligned.valid && (aligned.x == X_LAST) && (aligned.y == Y_LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vga_plot   <= aligned.valid;
            frame_done <= last_pixel;
            if (aligned.valid) begin
                vga_x      <= aligned.x;
                vga_y      <= aligned.y;
                vga_colour <= resolved;
            end
        end
    end

    // Flagged in the same cycle as the rejected tick; the frame in flight is untouched.
    assign overrun = frame_tick && busy;

endmodule

// File: tb/tb_trap_frame_scheduler.sv
// Bench for trap_frame_scheduler: three instances (4x3 L=1, 4x3 L=3, 320x240 L=1)
// with renderer models and per-instance plot scoreboards.
module tb_trap_frame_scheduler;
    import trap_pkg::*;

    typedef struct {
        int         cyc;
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] c;
        logic       last;
    } exp_t;

    typedef struct {
        logic [2:0] hit;
        logic [8:0] col;
        logic [2:0] exp_c;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // ---------------- instance A: 4x3, L=1, BG=001 ----------------
    logic       resetn_a = 1'b0, frame_tick_a = 1'b0;
    logic [8:0] x_cord_a, y_cord_a, vga_x_a, vga_y_a;
    logic [8:0] layer_colour_a;
    logic [2:0] layer_hit_a, vga_colour_a;
    logic       vga_plot_a, busy_a, frame_done_a, overrun_a;

    logic       a_static = 1'b0;
    logic [2:0] st_hit = 3'b000, a_exp_static = 3'b000;
    logic [8:0] st_col = 9'd0;
    logic [2:0] ra_hit;
    logic [8:0] ra_col;

    always @(posedge clk) begin
        ra_hit <= {x_cord_a == 9'd2, 1'b0, 1'b1};
        ra_col <= {YELLOW, WHITE, RED};
    end
    assign layer_hit_a    = a_static ? st_hit : ra_hit;
    assign layer_colour_a = a_static ? st_col : ra_col;

    trap_frame_scheduler #(
        .SCREEN_W(4), .SCREEN_H(3), .LAYERS(3), .RENDER_LATENCY(1), .BG_COLOUR(3'b001)
    ) dut_a (
        .clock(clk), .resetn(resetn_a), .frame_tick(frame_tick_a),
        .x_cord(x_cord_a), .y_cord(y_cord_a),
        .layer_colour(layer_colour_a), .layer_hit(layer_hit_a),
        .vga_x(vga_x_a), .vga_y(vga_y_a), .vga_colour(vga_colour_a), .vga_plot(vga_plot_a),
        .busy(busy_a), .frame_done(frame_done_a), .overrun(overrun_a)
    );

    // ---------------- instance B: 4x3, L=3 ----------------
    logic       resetn_b = 1'b0, frame_tick_b = 1'b0;
    logic [8:0] x_cord_b, y_cord_b, vga_x_b, vga_y_b;
    logic [2:0] vga_colour_b;
    logic       vga_plot_b, busy_b, frame_done_b, overrun_b;
    logic [2:0] rb_hit [3];
    logic [8:0] rb_col [3];
    logic [8:0] sum_b;

    assign sum_b = x_cord_b + y_cord_b;
    always @(posedge clk) begin
        rb_hit[0] <= {sum_b == 9'd4, 2'b11};
        rb_col[0] <= {BLACK, sum_b[2:0], WHITE};
        for (int i = 1; i < 3; i++) begin
            rb_hit[i] <= rb_hit[i-1];
            rb_col[i] <= rb_col[i-1];
        end
    end

    trap_frame_scheduler #(
        .SCREEN_W(4), .SCREEN_H(3), .LAYERS(3), .RENDER_LATENCY(3), .BG_COLOUR(3'b000)
    ) dut_b (
        .clock(clk), .resetn(resetn_b), .frame_tick(frame_tick_b),
        .x_cord(x_cord_b), .y_cord(y_cord_b),
        .layer_colour(rb_col[2]), .layer_hit(rb_hit[2]),
        .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b), .vga_plot(vga_plot_b),
        .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
    );

    // ---------------- instance C: 320x240, L=1 ----------------
    logic       resetn_c = 1'b0, frame_tick_c = 1'b0;
    logic [8:0] x_cord_c, y_cord_c, vga_x_c, vga_y_c;
    logic [2:0] vga_colour_c;
    logic       vga_plot_c, busy_c, frame_done_c, overrun_c;
    logic [8:0] c_last_x = 9'd0, c_last_y = 9'd0;
    int         c_plots = 0;

    trap_frame_scheduler #(
        .SCREEN_W(320), .SCREEN_H(240), .LAYERS(3), .RENDER_LATENCY(1), .BG_COLOUR(3'b000)
    ) dut_c (
        .clock(clk), .resetn(resetn_c), .frame_tick(frame_tick_c),
        .x_cord(x_cord_c), .y_cord(y_cord_c),
        .layer_colour(9'd0), .layer_hit(3'b000),
        .vga_x(vga_x_c), .vga_y(vga_y_c), .vga_colour(vga_colour_c), .vga_plot(vga_plot_c),
        .busy(busy_c), .frame_done(frame_done_c), .overrun(overrun_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic [2:0] exp_colour(input int which, input int x, input int y);
        case (which)
            0:       return a_static ? a_exp_static : ((x == 2) ? YELLOW : RED);
            1:       return ((x + y) == 4) ? BLACK : 3'((x + y) % 8);
            default: return BLACK;
        endcase
    endfunction

    // Queue every pixel of a frame whose tick is seen in cycle t.
    task automatic push_frame(input int which, input int t);
        int   w, h, l, idx;
        exp_t e;
        w   = (which == 2) ? 320 : 4;
        h   = (which == 2) ? 240 : 3;
        l   = (which == 1) ? 3 : 1;
        idx = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.cyc  = t + l + 2 + idx;
                e.x    = 9'(x);
                e.y    = 9'(y);
                e.c    = exp_colour(which, x, y);
                e.last = (idx == w * h - 1);
                if (which == 0) q_a.push_back(e);
                else if (which == 1) q_b.push_back(e);
                else q_c.push_back(e);
                idx++;
            end
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = (i >= lo) && (i <= hi);
        return r;
    endfunction

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (mon_en) begin
            if (vga_plot_a) begin
                if (q_a.size() == 0) check("a_extra_plot", 32'd1, 32'd0);
                else begin
                    e = q_a.pop_front();
                    check("a_plot_cycle", cyc, e.cyc);
                    check("a_x", vga_x_a, e.x);
                    check("a_y", vga_y_a, e.y);
                    check("a_colour", vga_colour_a, e.c);
                    check("a_done", frame_done_a, e.last);
                end
            end else check("a_done_no_plot", frame_done_a, 32'd0);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (mon_en) begin
            if (vga_plot_b) begin
                if (q_b.size() == 0) check("b_extra_plot", 32'd1, 32'd0);
                else begin
                    e = q_b.pop_front();
                    check("b_plot_cycle", cyc, e.cyc);
                    check("b_x", vga_x_b, e.x);
                    check("b_y", vga_y_b, e.y);
                    check("b_colour", vga_colour_b, e.c);
                    check("b_done", frame_done_b, e.last);
                end
            end else check("b_done_no_plot", frame_done_b, 32'd0);
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (mon_en && vga_plot_c) begin
            if (q_c.size() == 0) check("c_extra_plot", 32'd1, 32'd0);
            else begin
                e = q_c.pop_front();
                c_plots++;
                c_last_x = vga_x_c;
                c_last_y = vga_y_c;
                check("c_plot_cycle", cyc, e.cyc);
                check("c_xy", {vga_x_c, vga_y_c}, {e.x, e.y});
                check("c_colour", vga_colour_c, e.c);
                check("c_done", frame_done_c, e.last);
            end
        end
    end

    // Cycle-by-cycle sequence on instance A; bit k of each mask refers to cycle k.
    task automatic seq_a(input logic [63:0] tick_m, input logic [63:0] acc_m,
                         input logic [63:0] rst_m, input logic [63:0] busy_m,
                         input logic [63:0] ovr_m, input int ncyc);
        exp_t tail;
        for (int k = 0; k < ncyc; k++) begin
            frame_tick_a = tick_m[k];
            resetn_a     = ~rst_m[k];
            if (acc_m[k]) push_frame(0, cyc);
            if (rst_m[k]) begin
                while (q_a.size() > 0) begin
                    tail = q_a[q_a.size()-1];
                    if (tail.cyc <= cyc) break;
                    void'(q_a.pop_back());
                end
            end
            @(negedge clk);
            check("a_busy", busy_a, busy_m[k]);
            check("a_overrun", overrun_a, ovr_m[k]);
            @(posedge clk);
            #1;
        end
        frame_tick_a = 1'b0;
        resetn_a     = 1'b1;
        check("a_pending", q_a.size(), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{hit: 3'b000, col: {RED, YELLOW, WHITE},   exp_c: 3'b001};
        vecs[1] = '{hit: 3'b001, col: {RED, YELLOW, WHITE},   exp_c: WHITE};
        vecs[2] = '{hit: 3'b011, col: {RED, YELLOW, WHITE},   exp_c: YELLOW};
        vecs[3] = '{hit: 3'b111, col: {RED, YELLOW, WHITE},   exp_c: RED};
        vecs[4] = '{hit: 3'b101, col: {BLACK, YELLOW, WHITE}, exp_c: BLACK};
        vecs[5] = '{hit: 3'b010, col: {RED, BLACK, WHITE},    exp_c: BLACK};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_plot", vga_plot_a, 32'd0);
        check("rst_busy", busy_a, 32'd0);
        check("rst_done", frame_done_a, 32'd0);
        check("rst_overrun", overrun_a, 32'd0);
        check("rst_cord", {x_cord_a, y_cord_a}, 32'd0);
        check("rst_vga_xy", {vga_x_a, vga_y_a}, 32'd0);
        check("rst_colour", vga_colour_a, 32'd1);
        check("rst_b_plot", vga_plot_b, 32'd0);
        check("rst_c_busy", busy_c, 32'd0);
        @(posedge clk);
        #1;
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        resetn_c = 1'b1;
        mon_en   = 1'b1;

        // Basic frame with priority pattern (layer 2 at x==2 over layer 0).
        seq_a(64'h1, 64'h1, 64'h0, rng(1, 14), 64'h0, 17);

        // Static layer inputs applied for whole frames.
        a_static = 1'b1;
        for (int v = 0; v < 6; v++) begin
            st_hit       = vecs[v].hit;
            st_col       = vecs[v].col;
            a_exp_static = vecs[v].exp_c;
            seq_a(64'h1, 64'h1, 64'h0, rng(1, 14), 64'h0, 17);
        end
        a_static = 1'b0;

        // Overrun: ticks at 0, 5, 14 (done cycle) and 15 (accepted).
        seq_a((64'h1 << 0) | (64'h1 << 5) | (64'h1 << 14) | (64'h1 << 15),
              (64'h1 << 0) | (64'h1 << 15), 64'h0,
              rng(1, 14) | rng(16, 29),
              (64'h1 << 5) | (64'h1 << 14), 32);

        // Mid-frame reset in cycle 7, restart at 9.
        seq_a((64'h1 << 0) | (64'h1 << 9), (64'h1 << 0) | (64'h1 << 9), 64'h1 << 7,
              rng(1, 7) | rng(10, 23), 64'h0, 26);

        // Longer renderer latency on instance B.
        frame_tick_b = 1'b1;
        push_frame(1, cyc);
        @(posedge clk);
        #1;
        frame_tick_b = 1'b0;
        for (int k = 0; k < 40 && q_b.size() > 0; k++) @(posedge clk);
        check("b_pending", q_b.size(), 32'd0);

        // Full-resolution frame on instance C.
        @(posedge clk);
        #1;
        frame_tick_c = 1'b1;
        push_frame(2, cyc);
        @(posedge clk);
        #1;
        frame_tick_c = 1'b0;
        for (int k = 0; k < 77000 && q_c.size() > 0; k++) @(posedge clk);
        check("c_pending", q_c.size(), 32'd0);
        check("c_plot_count", c_plots, 32'd76800);
        check("c_final_xy", {c_last_x, c_last_y}, {9'd319, 9'd239});
        @(negedge clk);
        check("c_busy_after", busy_c, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
